// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - control word field positions and mode encodings for the LED pattern driver
package led_pattern_pkg;

   localparam int CTRL_BASE_LSB = 0;
   localparam int CTRL_DUTY_LSB = 8;
   localparam int CTRL_MODE_LSB = 16;
   localparam int CTRL_RATE_LSB = 20;
   localparam int CTRL_EN_BIT   = 31;

   typedef enum logic [2:0] {
      MODE_STATIC  = 3'd0,
      MODE_BLINK   = 3'd1,
      MODE_SHIFT   = 3'd2,
      MODE_BOUNCE  = 3'd3,
      MODE_PWM     = 3'd4,
      MODE_BREATHE = 3'd5,
      MODE_RSVD6   = 3'd6,
      MODE_RSVD7   = 3'd7
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   typedef struct packed {
      logic       en;
      logic [7:0] rate;
      mode_e      mode;
      logic [7:0] duty;
      logic [7:0] base;
   } ctrl_t;

endpackage

// File: rtl/led_pattern_driver_if.sv
// rtl/led_pattern_driver_if.sv - control word in, LED drive and pattern pulses out
interface led_pattern_driver_if #(
   parameter int NUM_LEDS = 8
);
   logic [31:0]         ctrl_word;
   logic [NUM_LEDS-1:0] led_out;
   logic                step_pulse;
   logic                wrap_pulse;

   modport master (output ctrl_word, input led_out, step_pulse, wrap_pulse);
   modport slave  (input ctrl_word, output led_out, step_pulse, wrap_pulse);
endinterface

// File: rtl/led_step_timer.sv
// rtl/led_step_timer.sv - free-running tick divider and rate-scaled step counter
module led_step_timer #(
   parameter int TICK_DIV = 50000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clear_i,
   input  logic [7:0] rate_i,
   output logic       tick_o,
   output logic       step_o
);
   localparam int            TW        = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [7:0]    step_cnt_q, step_cnt_d;
   logic [7:0]    step_last;

   always_comb begin
      tick_o     = (tick_cnt_q == TICK_LAST);
      step_last  = (rate_i == 8'd0) ? 8'd0 : rate_i - 8'd1;
      // >= so that lowering rate below the running count still steps promptly
      step_o     = tick_o && !clear_i && (step_cnt_q >= step_last);
      tick_cnt_d = tick_o ? '0 : tick_cnt_q + TW'(1);
      step_cnt_d = step_cnt_q;
      if (clear_i) begin
         step_cnt_d = '0;
      end else if (step_o) begin
         step_cnt_d = '0;
      end else if (tick_o) begin
         step_cnt_d = step_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt_q <= '0;
         step_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         step_cnt_q <= step_cnt_d;
      end
   end
endmodule

// File: rtl/led_pattern_driver.sv
// rtl/led_pattern_driver.sv - LED pattern state machine and output register; LED_PATTERN_BREATHE_EN enables mode 5 breathing
module led_pattern_driver
   import led_pattern_pkg::*;
#(
   parameter int NUM_LEDS = 8,
   parameter int TICK_DIV = 50000
) (
   input logic                 clk,
   input logic                 reset_n,
   led_pattern_driver_if.slave bus
);
   localparam logic [2:0] LAST_POS = 3'(NUM_LEDS - 1);

   ctrl_t               ctrl_q, ctrl_d;
   mode_e               prev_mode_q;
   logic [7:0]          prev_base_q;
   logic                prev_en_q;
   logic [7:0]          pwm_cnt_q;
   logic                phase_q, phase_d;
   logic [NUM_LEDS-1:0] rot_q, rot_d;
   logic [2:0]          pos_q, pos_d;
   dir_e                dir_q, dir_d;
   logic [NUM_LEDS-1:0] led_q, led_d;
   logic                step_q, step_d;
   logic                wrap_q, wrap_d;
   logic                restart, hold;
   logic                timer_step, timer_tick_unused;
   logic [NUM_LEDS-1:0] base_m;
   logic                unused_ctrl_bits;
`ifdef LED_PATTERN_BREATHE_EN
   localparam logic [7:0] BREATHE_STEP = 8'd8;
   localparam logic [7:0] BREATHE_TOP  = 8'd248;
   logic [7:0]          level_q, level_d;
   dir_e                level_dir_q, level_dir_d;
`endif

   always_comb begin
      ctrl_d.en   = bus.ctrl_word[CTRL_EN_BIT];
      ctrl_d.rate = bus.ctrl_word[CTRL_RATE_LSB +: 8];
      ctrl_d.mode = mode_e'(bus.ctrl_word[CTRL_MODE_LSB +: 3]);
      ctrl_d.duty = bus.ctrl_word[CTRL_DUTY_LSB +: 8];
      ctrl_d.base = bus.ctrl_word[CTRL_BASE_LSB +: 8];
   end
   assign unused_ctrl_bits = ^{bus.ctrl_word[30:28], bus.ctrl_word[19]};
   assign base_m = ctrl_q.base[NUM_LEDS-1:0];

   led_step_timer #(.TICK_DIV(TICK_DIV)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear_i (hold),
      .rate_i  (ctrl_q.rate),
      .tick_o  (timer_tick_unused),
      .step_o  (timer_step)
   );

   always_comb begin
      restart = ctrl_q.en && ((ctrl_q.mode != prev_mode_q) ||
                              (ctrl_q.base != prev_base_q) || !prev_en_q);
      hold    = !ctrl_q.en || restart;
      phase_d = phase_q;
      rot_d   = rot_q;
      pos_d   = pos_q;
      dir_d   = dir_q;
`ifdef LED_PATTERN_BREATHE_EN
      level_d     = level_q;
      level_dir_d = level_dir_q;
`endif
      step_d  = 1'b0;
      wrap_d  = 1'b0;
      led_d   = '0;

      if (hold) begin
         phase_d = 1'b1;
         rot_d   = base_m;
         pos_d   = '0;
         dir_d   = DIR_UP;
`ifdef LED_PATTERN_BREATHE_EN
         level_d     = '0;
         level_dir_d = DIR_UP;
`endif
      end else if (timer_step) begin
         case (ctrl_q.mode)
            MODE_BLINK: begin
               step_d  = 1'b1;
               phase_d = !phase_q;
               wrap_d  = !phase_q;
            end
            MODE_SHIFT: begin
               // pos counts steps here so the wrap lands after NUM_LEDS rotations
               step_d = 1'b1;
               rot_d  = (rot_q << 1) | (rot_q >> (NUM_LEDS - 1));
               if (pos_q == LAST_POS) begin
                  pos_d  = '0;
                  wrap_d = 1'b1;
               end else begin
                  pos_d = pos_q + 3'd1;
               end
            end
            MODE_BOUNCE: begin
               step_d = 1'b1;
               if (NUM_LEDS == 1) begin
                  wrap_d = 1'b1;
               end else begin
                  pos_d = (dir_q == DIR_UP) ? pos_q + 3'd1 : pos_q - 3'd1;
                  if (pos_d == LAST_POS) begin
                     dir_d = DIR_DOWN;
                  end else if (pos_d == 3'd0) begin
                     dir_d  = DIR_UP;
                     wrap_d = 1'b1;
                  end
               end
            end
`ifdef LED_PATTERN_BREATHE_EN
            MODE_BREATHE: begin
               step_d  = 1'b1;
               level_d = (level_dir_q == DIR_UP) ? level_q + BREATHE_STEP
                                                 : level_q - BREATHE_STEP;
               if (level_d == BREATHE_TOP) begin
                  level_dir_d = DIR_DOWN;
               end else if (level_d == 8'd0) begin
                  level_dir_d = DIR_UP;
                  wrap_d      = 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end

      // LED drive follows next state so it moves on the same edge as step_pulse
      if (ctrl_q.en) begin
         case (ctrl_q.mode)
            MODE_BLINK:   led_d = phase_d ? base_m : '0;
            MODE_SHIFT:   led_d = rot_d;
            MODE_BOUNCE:  led_d = NUM_LEDS'(1) << pos_d;
            MODE_PWM:     led_d = (pwm_cnt_q < ctrl_q.duty) ? base_m : '0;
`ifdef LED_PATTERN_BREATHE_EN
            MODE_BREATHE: led_d = (pwm_cnt_q < level_d) ? base_m : '0;
`endif
            default:      led_d = base_m;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q      <= '0;
         prev_mode_q <= MODE_STATIC;
         prev_base_q <= '0;
         prev_en_q   <= 1'b0;
         pwm_cnt_q   <= '0;
         phase_q     <= 1'b1;
         rot_q       <= '0;
         pos_q       <= '0;
         dir_q       <= DIR_UP;
         led_q       <= '0;
         step_q      <= 1'b0;
         wrap_q      <= 1'b0;
`ifdef LED_PATTERN_BREATHE_EN
         level_q     <= '0;
         level_dir_q <= DIR_UP;
`endif
      end else begin
         ctrl_q      <= ctrl_d;
         prev_mode_q <= ctrl_q.mode;
         prev_base_q <= ctrl_q.base;
         prev_en_q   <= ctrl_q.en;
         pwm_cnt_q   <= pwm_cnt_q + 8'd1;
         phase_q     <= phase_d;
         rot_q       <= rot_d;
         pos_q       <= pos_d;
         dir_q       <= dir_d;
         led_q       <= led_d;
         step_q      <= step_d;
         wrap_q      <= wrap_d;
`ifdef LED_PATTERN_BREATHE_EN
         level_q     <= level_d;
         level_dir_q <= level_dir_d;
`endif
      end
   end

   assign bus.led_out    = led_q;
   assign bus.step_pulse = step_q;
   assign bus.wrap_pulse = wrap_q;
endmodule
